// File: rtl/receiver_if.sv
// Serial receive bus: the line into the receiver plus the byte/status strobes out of it.
// master = line driver and byte consumer side, slave = receiver side.
interface receiver_if;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   modport master (output rxd, input rx_data, rx_valid, frame_err, busy);
   modport slave  (input rxd, output rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, stop-bit check.
// Delivers each good byte with a one-cycle rx_valid strobe and flags bad stop bits.
module receiver #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic      clk,
   input  logic      rst,
   receiver_if.slave bus
);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync;
   logic          rxd_s;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic [7:0]    rx_data;
   logic          rx_valid, frame_err, busy;
   logic          bit_tick, stop_tick;

   // Synchroniser resets high so releasing reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], bus.rxd};
   end
   assign rxd_s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rxd_s) state_nxt = START;
         START:     if (baud_cnt == HALF_LAST) state_nxt = rxd_s ? IDLE : DATA;
         DATA:      if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
         STOP:      if (stop_tick) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rxd_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      bit_tick  = (state == DATA) && (baud_cnt == BIT_LAST);
      stop_tick = (state == STOP) && (baud_cnt == BIT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= stop_tick && rxd_s;
         frame_err <= stop_tick && !rxd_s;

         if (state == IDLE || state_nxt != state || bit_tick) baud_cnt <= '0;
         else                                                 baud_cnt <= baud_cnt + 1'b1;

         if (state != DATA)  bit_idx <= '0;
         else if (bit_tick)  bit_idx <= bit_idx + 1'b1;

         // Shifting right into the MSB leaves bit 0 (sent first) in the LSB after 8 samples.
         if (bit_tick) shift_reg <= {rxd_s, shift_reg[7:1]};

         if (stop_tick && rxd_s) rx_data <= shift_reg;
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: a bit-level 8N1 line model drives two instances (16 and 13 clocks/bit)
// and received bytes, strobes and latencies are compared with expectations built from the frames sent.
module tb_receiver;
   localparam int C16 = 16;
   localparam int C13 = 13;
   localparam int LAT16 = C16 / 2 + 9 * C16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   receiver_if b16 ();
   receiver_if b13 ();

   receiver #(.CLKS_PER_BIT(C16)) u16 (.clk(clk), .rst(rst), .bus(b16));
   receiver #(.CLKS_PER_BIT(C13)) u13 (.clk(clk), .rst(rst), .bus(b13));

   int n_vec = 0;
   int n_err = 0;

   int          cyc = 0;
   int          rise16 = 0;
   logic        busy16_q = 1'b0;
   byte unsigned got16[$];
   byte unsigned got13[$];
   int          lat16[$];
   int          ferr16 = 0;
   int          ferr13 = 0;
   int          excl = 0;

   // Event recorder: everything observed at the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (b16.busy && !busy16_q) rise16 = cyc;
         busy16_q = b16.busy;
         if (b16.rx_valid) begin
            got16.push_back(b16.rx_data);
            lat16.push_back(cyc - rise16);
         end
         if (b13.rx_valid) got13.push_back(b13.rx_data);
         if (b16.frame_err) ferr16++;
         if (b13.frame_err) ferr13++;
         if ((b16.rx_valid && b16.frame_err) || (b13.rx_valid && b13.frame_err)) excl++;
      end
   end

   task automatic send_bit(input int sel, input logic b);
      if (sel == 0) begin b16.rxd = b; repeat (C16) @(negedge clk); end
      else          begin b13.rxd = b; repeat (C13) @(negedge clk); end
   endtask

   task automatic send_frame(input int sel, input byte unsigned d, input logic stop);
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
      send_bit(sel, stop);
   endtask

   task automatic test_reset;
      b16.rxd = 1'b1;
      b13.rxd = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (b16.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got %h want 00", b16.rx_data); end
      n_vec++; if (b16.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %b want 0", b16.rx_valid); end
      n_vec++; if (b16.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", b16.frame_err); end
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", b16.busy); end
      rst = 1'b0;
      repeat (C16) @(negedge clk);
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", b16.busy); end
   endtask

   task automatic test_single;
      int n0 = got16.size();
      int f0 = ferr16;
      send_frame(0, 8'hA5, 1'b1);
      repeat (2 * C16) @(negedge clk);
      n_vec++; if (got16.size() - n0 !== 1) begin n_err++; $display("FAIL single_count got %0d want 1", got16.size() - n0); end
      if (got16.size() > n0) begin
         n_vec++; if (got16[n0] !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", got16[n0]); end
         n_vec++; if (lat16[n0] !== LAT16) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat16[n0], LAT16); end
      end
      n_vec++; if (ferr16 - f0 !== 0) begin n_err++; $display("FAIL single_ferr got %0d want 0", ferr16 - f0); end
      n_vec++; if (b16.rx_data !== 8'hA5) begin n_err++; $display("FAIL single_hold got %h want a5", b16.rx_data); end
   endtask

   task automatic test_back_to_back;
      byte unsigned pat[3] = '{8'h00, 8'hFF, 8'h3C};
      int n0 = got16.size();
      for (int i = 0; i < 3; i++) send_frame(0, pat[i], 1'b1);
      repeat (C16) @(negedge clk);
      n_vec++; if (got16.size() - n0 !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", got16.size() - n0); end
      for (int i = 0; i < 3; i++)
         if (got16.size() > n0 + i) begin
            n_vec++; if (got16[n0 + i] !== pat[i]) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", i, got16[n0 + i], pat[i]); end
         end
   endtask

   task automatic test_glitch;
      int n0 = got16.size();
      int f0 = ferr16;
      b16.rxd = 1'b0;
      repeat (4) @(negedge clk);
      b16.rxd = 1'b1;
      n_vec++; if (b16.busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_rise got %b want 1", b16.busy); end
      repeat (2 * C16) @(negedge clk);
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle got %b want 0", b16.busy); end
      n_vec++; if (got16.size() - n0 + ferr16 - f0 !== 0) begin n_err++; $display("FAIL glitch_strobe got %0d want 0", got16.size() - n0 + ferr16 - f0); end
      send_frame(0, 8'h5A, 1'b1);
      repeat (C16) @(negedge clk);
      n_vec++; if (b16.rx_data !== 8'h5A || got16.size() - n0 !== 1) begin n_err++; $display("FAIL glitch_next_frame got %h/%0d want 5a/1", b16.rx_data, got16.size() - n0); end
   endtask

   task automatic test_frame_err;
      int n0 = got16.size();
      int f0 = ferr16;
      send_frame(0, 8'h81, 1'b0);
      b16.rxd = 1'b0;
      repeat (40) @(negedge clk);
      n_vec++; if (b16.busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_held got %b want 1", b16.busy); end
      n_vec++; if (ferr16 - f0 !== 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", ferr16 - f0); end
      n_vec++; if (got16.size() - n0 !== 0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", got16.size() - n0); end
      n_vec++; if (b16.rx_data !== 8'h5A) begin n_err++; $display("FAIL ferr_rx_data_hold got %h want 5a", b16.rx_data); end
      b16.rxd = 1'b1;
      repeat (5) @(negedge clk);
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL ferr_recover got %b want 0", b16.busy); end
      n_vec++; if (ferr16 - f0 !== 1) begin n_err++; $display("FAIL ferr_no_second got %0d want 1", ferr16 - f0); end
   endtask

   task automatic test_reset_mid;
      byte unsigned d = 8'h96;
      int n0;
      send_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(0, d[i]);
      b16.rxd = d[3];
      repeat (C16 / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", b16.busy); end
      n_vec++; if (b16.rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_rx_data got %h want 00", b16.rx_data); end
      n_vec++; if (b16.rx_valid !== 1'b0 || b16.frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_strobes got %b%b want 00", b16.rx_valid, b16.frame_err); end
      b16.rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n0 = got16.size();
      repeat (2 * C16) @(negedge clk);
      n_vec++; if (got16.size() - n0 !== 0) begin n_err++; $display("FAIL rstmid_no_strobe got %0d want 0", got16.size() - n0); end
      send_frame(0, d, 1'b1);
      repeat (C16) @(negedge clk);
      n_vec++; if (b16.rx_data !== 8'h96 || got16.size() - n0 !== 1) begin n_err++; $display("FAIL rstmid_next_frame got %h/%0d want 96/1", b16.rx_data, got16.size() - n0); end
   endtask

   // Random frames, gaps and bad stop bits; reference is a queue of the bytes that should land.
   task automatic test_random;
      byte unsigned exp_q[$];
      byte unsigned last_good = b16.rx_data;
      int exp_ferr = 0;
      int n0 = got16.size();
      int f0 = ferr16;
      for (int k = 0; k < 10; k++) begin
         byte unsigned d = byte'($urandom);
         logic good = ($urandom_range(0, 4) != 0);
         int gap = $urandom_range(0, 2);
         send_frame(0, d, good);
         if (good) begin exp_q.push_back(d); last_good = d; end
         else begin exp_ferr++; if (gap == 0) gap = 1; end
         b16.rxd = 1'b1;
         repeat (gap * C16) @(negedge clk);
      end
      repeat (C16) @(negedge clk);
      n_vec++; if (got16.size() - n0 !== exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", got16.size() - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++)
         if (got16.size() > n0 + i) begin
            n_vec++; if (got16[n0 + i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data%0d got %h want %h", i, got16[n0 + i], exp_q[i]); end
            n_vec++; if (lat16[n0 + i] !== LAT16) begin n_err++; $display("FAIL rand_lat%0d got %0d want %0d", i, lat16[n0 + i], LAT16); end
         end
      n_vec++; if (ferr16 - f0 !== exp_ferr) begin n_err++; $display("FAIL rand_ferr got %0d want %0d", ferr16 - f0, exp_ferr); end
      n_vec++; if (b16.rx_data !== last_good) begin n_err++; $display("FAIL rand_hold got %h want %h", b16.rx_data, last_good); end
   endtask

   // Odd bit period: half-bit offset rounds down, exercising the integer divide.
   task automatic test_odd_period;
      byte unsigned exp_q[$];
      int n0 = got13.size();
      exp_q.push_back(8'h4B);
      for (int k = 0; k < 3; k++) exp_q.push_back(byte'($urandom));
      foreach (exp_q[i]) send_frame(1, exp_q[i], 1'b1);
      repeat (C13) @(negedge clk);
      n_vec++; if (got13.size() - n0 !== exp_q.size()) begin n_err++; $display("FAIL odd_count got %0d want %0d", got13.size() - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++)
         if (got13.size() > n0 + i) begin
            n_vec++; if (got13[n0 + i] !== exp_q[i]) begin n_err++; $display("FAIL odd_data%0d got %h want %h", i, got13[n0 + i], exp_q[i]); end
         end
      n_vec++; if (ferr13 !== 0) begin n_err++; $display("FAIL odd_ferr got %0d want 0", ferr13); end
   endtask

   initial begin
      b16.rxd = 1'b1;
      b13.rxd = 1'b1;
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_frame_err;
      test_reset_mid;
      test_random;
      test_odd_period;
      n_vec++; if (excl !== 0) begin n_err++; $display("FAIL valid_ferr_overlap got %0d want 0", excl); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
